tl45_pipe_ctrl: RTL

Central pipeline sequencer for the TL45 core. It watches the decode output buffer, the instruction in execute, the memory stage and branch resolution, and drives every stall, bubble and flush line. Fetch, decode and execute need no hazard logic of their own. Load-use interlocks, multi-cycle divide holds, branch squashes and decode-error traps are all handled here.

---
 rtl/tl45_pipe_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/tl45_pipe_ctrl.sv
// tl45_pipe_ctrl - central pipeline sequencer for the TL45 core.
//
// Drives every stall, bubble and flush line for fetch, decode and execute.
// It resolves memory back-pressure, taken branches, load-use interlocks,
// multi-cycle divides and illegal decode entries in a single priority chain.
//
// The stall, bubble and flush outputs are combinational from the current
// state and the inputs, so they act in the same cycle. State, the divide
// counter and the trap PC are registered.
//
// Optional feature macro: TL45_TRAP_EN
//   defined   : an illegal decode entry halts the core in TRAP until reset.
//   undefined : an illegal decode entry is squashed with a one-cycle bubble.
//               TRAP does not exist, and o_trap / o_trap_pc are tied to 0.

module tl45_pipe_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_dec_pc,
  input  logic [4:0]  i_dec_opcode,
  input  logic [3:0]  i_dec_sr1,
  input  logic [3:0]  i_dec_sr2,
  input  logic        i_dec_err,
  input  logic [4:0]  i_ex_opcode,
  input  logic [3:0]  i_ex_dr,
  input  logic        i_mem_busy,
  input  logic        i_br_taken,
  output logic        o_fetch_stall,
  output logic        o_dec_stall,
  output logic        o_ex_hold,
  output logic        o_ex_bubble,
  output logic        o_flush,
  output logic        o_div_busy,
  output logic        o_trap,
  output logic [31:0] o_trap_pc
);

  // The counter must hold DIV_CYCLES-1 on divide issue.
  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef TL45_TRAP_EN
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DIV  = 2'd1,
    ST_TRAP = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DIV  = 2'd1
  } state_e;
`endif

  // A load in execute: LB/LBU/LH/LHU/LW.
  function automatic logic is_load_f(input logic [4:0] op);
    logic res;
    case (op)
      5'h0F, 5'h10, 5'h11, 5'h12, 5'h14: res = 1'b1;
      default:                           res = 1'b0;
    endcase
    return res;
  endfunction

  // A multi-cycle divide: DIV/UDIV.
  function automatic logic is_div_f(input logic [4:0] op);
    logic res;
    case (op)
      5'h17, 5'h18: res = 1'b1;
      default:      res = 1'b0;
    endcase
    return res;
  endfunction

  state_e           state_r;
  state_e           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic             lu_s;

`ifdef TL45_TRAP_EN
  logic [31:0]      trap_pc_r;
  logic [31:0]      trap_pc_nx_s;
`else
  // The decode PC is only needed when trapping is enabled.
  logic             unused_dec_pc_s;
  assign unused_dec_pc_s = ^i_dec_pc;
`endif

  // Load-use hazard. r0 never creates a hazard. All other RAW cases are
  // covered by forwarding.
  always_comb begin
    lu_s = 1'b0;
    if (is_load_f(i_ex_opcode) && (i_ex_dr != 4'd0) &&
        ((i_ex_dr == i_dec_sr1) || (i_ex_dr == i_dec_sr2))) begin
      lu_s = 1'b1;
    end else begin
      lu_s = 1'b0;
    end
  end

  // Next-state, counter and pipeline-control outputs. The RUN priority order
  // is: memory busy, taken branch, load-use, decode error, then issue.
  always_comb begin
    state_nx_s    = state_r;
    cnt_nx_s      = cnt_r;
`ifdef TL45_TRAP_EN
    trap_pc_nx_s  = trap_pc_r;
`endif
    o_fetch_stall = 1'b0;
    o_dec_stall   = 1'b0;
    o_ex_hold     = 1'b0;
    o_ex_bubble   = 1'b0;
    o_flush       = 1'b0;
    o_div_busy    = 1'b0;
    o_trap        = 1'b0;
    o_trap_pc     = 32'd0;

    if (i_reset) begin
      // Keep the pipe empty while reset is held.
      o_flush     = 1'b1;
      o_ex_bubble = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (i_mem_busy) begin
            o_fetch_stall = 1'b1;
            o_dec_stall   = 1'b1;
            o_ex_hold     = 1'b1;
          end else if (i_br_taken) begin
            // The decode entry is on the wrong path and never issues.
            o_flush     = 1'b1;
            o_ex_bubble = 1'b1;
          end else if (lu_s) begin
            o_fetch_stall = 1'b1;
            o_dec_stall   = 1'b1;
            o_ex_bubble   = 1'b1;
          end else if (i_dec_err) begin
            o_ex_bubble = 1'b1;
`ifdef TL45_TRAP_EN
            trap_pc_nx_s = i_dec_pc;
            state_nx_s   = ST_TRAP;
`endif
          end else begin
            if (is_div_f(i_dec_opcode)) begin
              // The issue cycle counts as the first divide cycle.
              state_nx_s = ST_DIV;
              cnt_nx_s   = CNT_LOAD;
            end else begin
              state_nx_s = ST_RUN;
            end
          end
        end

        ST_DIV: begin
          o_div_busy    = 1'b1;
          o_fetch_stall = 1'b1;
          o_dec_stall   = 1'b1;
          o_ex_hold     = 1'b1;
          if (cnt_r == CNT_ONE) begin
            if (!i_mem_busy) begin
              // Execute releases the divide in this cycle.
              state_nx_s = ST_RUN;
              cnt_nx_s   = {CNT_W{1'b0}};
            end else begin
              // Park at 1 until the memory stage frees up.
              cnt_nx_s = CNT_ONE;
            end
          end else begin
            cnt_nx_s = cnt_r - CNT_ONE;
          end
        end

`ifdef TL45_TRAP_EN
        ST_TRAP: begin
          // Halted. Older stores may still drain through memory.
          o_trap        = 1'b1;
          o_trap_pc     = trap_pc_r;
          o_fetch_stall = 1'b1;
          o_dec_stall   = 1'b1;
          o_ex_bubble   = 1'b1;
          o_ex_hold     = i_mem_busy;
        end
`endif

        default: begin
          state_nx_s = ST_RUN;
          cnt_nx_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and divide-counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_RUN;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

`ifdef TL45_TRAP_EN
  // Trap PC register, captured on TRAP entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      trap_pc_r <= 32'd0;
    end else begin
      trap_pc_r <= trap_pc_nx_s;
    end
  end
`endif

endmodule
